// File: rtl/nn_result_display.sv
// Latches the NN argmax class on done's rising edge and shows it on one active-low 7-segment digit.
// A spinner runs while an inference is in flight. Optional NN_RESULT_COUNT_EN builds the completed-inference counter.
module nn_result_display #(
  parameter int SPIN_DIV = 25000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             done,
  input  logic [3:0]       argmax_output,
  output logic [6:0]       hex_out,
  output logic [3:0]       result_digit,
  output logic             result_valid,
  output logic             error,
  output logic             busy,
  output logic [CNT_W-1:0] infer_count
);

  localparam int SPIN_W = (SPIN_DIV > 1) ? $clog2(SPIN_DIV) : 1;
  localparam logic [SPIN_W-1:0] SPIN_MAX = SPIN_W'(SPIN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SHOW = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state_r, state_next_s;
  logic              start_q_r, done_q_r;
  logic              start_rise_s, done_rise_s, digit_ok_s;
  logic [SPIN_W-1:0] spin_cnt_r;
  logic [2:0]        spin_idx_r;
  logic [6:0]        hex_next_s;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  function automatic logic [6:0] spin_seg(input logic [2:0] idx);
    logic [6:0] seg;
    case (idx)
      3'd0:    seg = 7'b1111110;
      3'd1:    seg = 7'b1111101;
      3'd2:    seg = 7'b1111011;
      3'd3:    seg = 7'b1110111;
      3'd4:    seg = 7'b1101111;
      3'd5:    seg = 7'b1011111;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  assign start_rise_s = start & ~start_q_r;
  assign done_rise_s  = done & ~done_q_r;
  assign digit_ok_s   = (argmax_output <= 4'd9);

  // Next-state logic; a done edge in RUN takes priority over a start edge
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_rise_s) state_next_s = RUN;
        else              state_next_s = IDLE;
      end
      RUN: begin
        if (done_rise_s) state_next_s = digit_ok_s ? SHOW : ERR;
        else             state_next_s = RUN;
      end
      SHOW, ERR: begin
        if (start_rise_s) state_next_s = RUN;
        else              state_next_s = state_r;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Display glyph from the current state; registered below so it trails the state by one clock
  always_comb begin
    hex_next_s = 7'h7F;
    case (state_r)
      IDLE:    hex_next_s = 7'h7F;
      RUN:     hex_next_s = spin_seg(spin_idx_r);
      SHOW:    hex_next_s = digit_seg(result_digit);
      ERR:     hex_next_s = 7'b0000110;
      default: hex_next_s = 7'h7F;
    endcase
  end

  // State, edge detectors, latched result and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      start_q_r    <= 1'b0;
      done_q_r     <= 1'b0;
      result_digit <= 4'd0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      busy         <= 1'b0;
      hex_out      <= 7'h7F;
    end else begin
      state_r      <= state_next_s;
      start_q_r    <= start;
      done_q_r     <= done;
      result_valid <= (state_next_s == SHOW);
      error        <= (state_next_s == ERR);
      busy         <= (state_next_s == RUN);
      hex_out      <= hex_next_s;
      if (state_r == RUN && done_rise_s && digit_ok_s) begin
        result_digit <= argmax_output;
      end
    end
  end

  // Spinner timing; held at zero outside RUN so every entry into RUN starts at segment a
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spin_cnt_r <= '0;
      spin_idx_r <= 3'd0;
    end else if (state_r != RUN) begin
      spin_cnt_r <= '0;
      spin_idx_r <= 3'd0;
    end else if (spin_cnt_r == SPIN_MAX) begin
      spin_cnt_r <= '0;
      spin_idx_r <= (spin_idx_r == 3'd5) ? 3'd0 : spin_idx_r + 3'd1;
    end else begin
      spin_cnt_r <= spin_cnt_r + SPIN_W'(1);
    end
  end

`ifdef NN_RESULT_COUNT_EN
  logic [CNT_W-1:0] infer_count_r;

  // Counts every RUN exit caused by a done edge, valid or error class alike
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      infer_count_r <= '0;
    end else if (state_r == RUN && done_rise_s) begin
      infer_count_r <= infer_count_r + CNT_W'(1);
    end else begin
      infer_count_r <= infer_count_r;
    end
  end

  assign infer_count = infer_count_r;
`else
  assign infer_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_nn_result_display.sv
// Self-checking bench for nn_result_display: directed table, hand sequences, and randomized
// traffic against a cycle-level behavioural model of the display.
module tb_nn_result_display;

  localparam int SPIN_DIV = 4;
  localparam int CNT_W    = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, done;
  logic [3:0]       argmax;
  logic [6:0]       hex_out;
  logic [3:0]       result_digit;
  logic             result_valid, error, busy;
  logic [CNT_W-1:0] infer_count;

  int n_cmp  = 0;
  int n_fail = 0;

  nn_result_display #(.SPIN_DIV(SPIN_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .argmax_output(argmax),
    .hex_out(hex_out), .result_digit(result_digit), .result_valid(result_valid),
    .error(error), .busy(busy), .infer_count(infer_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_SHOW = 2, M_ERR = 3;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int         m_mode, m_age;
  logic       m_ps, m_pd;
  logic [3:0] m_digit;
  logic [6:0] m_hex;
  int         m_done_runs;

  function automatic logic [6:0] glyph();
    if (m_mode == M_RUN)  return ~(7'b0000001 << ((m_age / SPIN_DIV) % 6));
    if (m_mode == M_SHOW) return seg_tab[m_digit];
    if (m_mode == M_ERR)  return 7'b0000110;
    return 7'h7F;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_age = 0; m_ps = 1'b0; m_pd = 1'b0;
    m_digit = 4'd0; m_hex = 7'h7F; m_done_runs = 0;
  endtask

  task automatic model_step(input logic s, input logic d, input logic [3:0] a);
    logic sr, dr;
    sr = s & ~m_ps;
    dr = d & ~m_pd;
    m_hex = glyph();
    if (m_mode == M_RUN) begin
      if (dr) begin
        m_done_runs++;
        if (a <= 4'd9) begin m_digit = a; m_mode = M_SHOW; end
        else m_mode = M_ERR;
      end else m_age++;
    end else if (sr) begin
      m_mode = M_RUN; m_age = 0;
    end
    m_ps = s; m_pd = d;
  endtask

  function automatic logic [CNT_W-1:0] model_count();
`ifdef NN_RESULT_COUNT_EN
    return CNT_W'(m_done_runs % (1 << CNT_W));
`else
    return '0;
`endif
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("hex",   {1'b0, hex_out}, {1'b0, m_hex});
    check("digit", {4'd0, result_digit}, {4'd0, m_digit});
    check("valid", {7'd0, result_valid}, {7'd0, (m_mode == M_SHOW)});
    check("error", {7'd0, error}, {7'd0, (m_mode == M_ERR)});
    check("busy",  {7'd0, busy}, {7'd0, (m_mode == M_RUN)});
    check("count", 8'(infer_count), 8'(model_count()));
  endtask

  // One clock: drive inputs, advance model, sample #1 after the edge
  task automatic step(input logic s, input logic d, input logic [3:0] a);
    start = s; done = d; argmax = a;
    model_step(s, d, a);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_hex",  {1'b0, hex_out}, 8'h7F);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic s, d; logic [3:0] a;
    logic [6:0] hex; logic [3:0] dig; logic v, e, b; int runs;
  } vec_t;
  vec_t tbl [24];

  initial begin
    logic [CNT_W-1:0] exp_cnt;
    tbl[0]  = '{1'b0, 1'b0, 4'd0,  7'h7F, 4'd0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 4'd0,  7'h7F, 4'd0, 1'b0, 1'b0, 1'b1, 0};
    tbl[2]  = '{1'b0, 1'b0, 4'd0,  7'h7E, 4'd0, 1'b0, 1'b0, 1'b1, 0};
    tbl[3]  = '{1'b0, 1'b1, 4'd7,  7'h7E, 4'd7, 1'b1, 1'b0, 1'b0, 1};
    tbl[4]  = '{1'b0, 1'b1, 4'd7,  7'h78, 4'd7, 1'b1, 1'b0, 1'b0, 1};
    tbl[5]  = '{1'b0, 1'b0, 4'd3,  7'h78, 4'd7, 1'b1, 1'b0, 1'b0, 1};
    tbl[6]  = '{1'b1, 1'b1, 4'd3,  7'h78, 4'd7, 1'b0, 1'b0, 1'b1, 1};
    tbl[7]  = '{1'b1, 1'b1, 4'd3,  7'h7E, 4'd7, 1'b0, 1'b0, 1'b1, 1};
    tbl[8]  = '{1'b0, 1'b0, 4'd3,  7'h7E, 4'd7, 1'b0, 1'b0, 1'b1, 1};
    tbl[9]  = '{1'b1, 1'b1, 4'd12, 7'h7E, 4'd7, 1'b0, 1'b1, 1'b0, 2};
    tbl[10] = '{1'b0, 1'b0, 4'd0,  7'h06, 4'd7, 1'b0, 1'b1, 1'b0, 2};
    tbl[11] = '{1'b0, 1'b0, 4'd0,  7'h06, 4'd7, 1'b0, 1'b1, 1'b0, 2};
    tbl[12] = '{1'b1, 1'b0, 4'd0,  7'h06, 4'd7, 1'b0, 1'b0, 1'b1, 2};
    tbl[13] = '{1'b0, 1'b0, 4'd0,  7'h7E, 4'd7, 1'b0, 1'b0, 1'b1, 2};
    tbl[14] = '{1'b0, 1'b0, 4'd0,  7'h7E, 4'd7, 1'b0, 1'b0, 1'b1, 2};
    tbl[15] = '{1'b0, 1'b0, 4'd0,  7'h7E, 4'd7, 1'b0, 1'b0, 1'b1, 2};
    tbl[16] = '{1'b0, 1'b0, 4'd0,  7'h7E, 4'd7, 1'b0, 1'b0, 1'b1, 2};
    tbl[17] = '{1'b0, 1'b0, 4'd0,  7'h7D, 4'd7, 1'b0, 1'b0, 1'b1, 2};
    tbl[18] = '{1'b1, 1'b0, 4'd0,  7'h7D, 4'd7, 1'b0, 1'b0, 1'b1, 2};
    tbl[19] = '{1'b0, 1'b0, 4'd0,  7'h7D, 4'd7, 1'b0, 1'b0, 1'b1, 2};
    tbl[20] = '{1'b0, 1'b0, 4'd0,  7'h7D, 4'd7, 1'b0, 1'b0, 1'b1, 2};
    tbl[21] = '{1'b0, 1'b0, 4'd0,  7'h7B, 4'd7, 1'b0, 1'b0, 1'b1, 2};
    tbl[22] = '{1'b0, 1'b1, 4'd0,  7'h7B, 4'd0, 1'b1, 1'b0, 1'b0, 3};
    tbl[23] = '{1'b0, 1'b0, 4'd0,  7'h40, 4'd0, 1'b1, 1'b0, 1'b0, 3};

    reset = 1'b1; start = 1'b0; done = 1'b0; argmax = 4'd0;
    #2;
    do_reset();

    // Directed table: spinner, capture, error glyph, simultaneous edges
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].s, tbl[i].d, tbl[i].a);
`ifdef NN_RESULT_COUNT_EN
      exp_cnt = CNT_W'(tbl[i].runs % (1 << CNT_W));
`else
      exp_cnt = '0;
`endif
      check($sformatf("tbl%0d_hex", i),   {1'b0, hex_out}, {1'b0, tbl[i].hex});
      check($sformatf("tbl%0d_dig", i),   {4'd0, result_digit}, {4'd0, tbl[i].dig});
      check($sformatf("tbl%0d_flags", i), {5'd0, result_valid, error, busy},
            {5'd0, tbl[i].v, tbl[i].e, tbl[i].b});
      check($sformatf("tbl%0d_cnt", i),   8'(infer_count), 8'(exp_cnt));
    end

    // Reset in the middle of a run: immediate blank, stays blank without pulses
    step(1'b1, 1'b0, 4'd0);
    repeat (5) step(1'b0, 1'b0, 4'd0);
    do_reset();
    repeat (4) step(1'b0, 1'b0, 4'd0);
    check("post_rst_hex", {1'b0, hex_out}, 8'h7F);

    // Done held high across start must not capture until it falls and rises again
    step(1'b0, 1'b1, 4'd5);
    step(1'b1, 1'b1, 4'd5);
    repeat (3) step(1'b0, 1'b1, 4'd5);
    check("held_done_busy", {7'd0, busy}, 8'd1);
    step(1'b0, 1'b0, 4'd5);
    step(1'b0, 1'b1, 4'd5);
    check("held_done_dig", {4'd0, result_digit}, 8'd5);

    // Five completed runs exercise counter wrap
    do_reset();
    for (int r = 0; r < 5; r++) begin
      step(1'b1, 1'b0, 4'(r));
      step(1'b0, 1'b1, 4'(r + 9));
      step(1'b0, 1'b0, 4'd0);
`ifdef NN_RESULT_COUNT_EN
      exp_cnt = CNT_W'((r + 1) % 4);
`else
      exp_cnt = '0;
`endif
      check($sformatf("runs%0d_cnt", r + 1), 8'(infer_count), 8'(exp_cnt));
    end

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      else step($urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3, 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
